pos_cell_access_ctrl: RTL and testbench

// Sequences one single-port position cell RAM (2-cycle read latency; word 0 = particle count; words 1..N = {posz,posy,posx}).

---
 rtl/pos_cell_access_ctrl_if.sv | 39 +++
 rtl/pos_cell_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_pos_cell_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pos_cell_access_ctrl_if.sv
// Handshake, stream and RAM-side signals of the position cell access controller.
interface pos_cell_access_ctrl_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_req;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] pos_out;
  logic                  pos_valid;
  logic                  pos_last;
  logic [ADDR_WIDTH-1:0] particle_id;
  logic                  rd_done;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  wr_done;
  logic                  wr_ovf;
  logic                  cnt_err;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  rd_req, wr_valid, wr_data, wr_last, mem_q,
    output rd_ack, pos_out, pos_valid, pos_last, particle_id, rd_done,
           wr_ready, wr_done, wr_ovf, cnt_err,
           mem_address, mem_data, mem_rden, mem_wren
  );

  modport master (
    output rd_req, wr_valid, wr_data, wr_last, mem_q,
    input  rd_ack, pos_out, pos_valid, pos_last, particle_id, rd_done,
           wr_ready, wr_done, wr_ovf, cnt_err,
           mem_address, mem_data, mem_rden, mem_wren
  );
endinterface

// File: rtl/pos_cell_access_ctrl.sv
// Arbitrates one single-port position cell RAM between a whole-cell reader and a whole-cell writer.
// Read beats land 2 cycles after their address; no stream backpressure, writer is throttled by wr_ready.
module pos_cell_access_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  pos_cell_access_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] MAX_N   = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_SAT = ADDR_WIDTH'(PARTICLE_NUM);

  typedef enum logic [2:0] {IDLE, RD_CNT, RD_WAIT, RD_STREAM, RD_DRAIN, WR, WR_CNT} state_t;
  typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

  state_t                state, state_nxt;
  grant_t                last_grant;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic                  rden_q, rden_nxt, wren_q, wren_nxt;
  logic                  grant_rd, grant_wr;
  logic                  wait_q, cnt_capture;
  logic [ADDR_WIDTH-1:0] n_q, cnt_raw, cnt_clamp;
  logic                  v1_q, v2_q;
  logic [ADDR_WIDTH-1:0] id1_q, id2_q;
  logic [ADDR_WIDTH-1:0] beat_cnt, beat_clamp;
  logic                  wr_fin_q, wr_rdy, wr_accept;
  logic                  rd_zero_q, cnt_err_q, wr_ovf_q, beat_last;

  assign cnt_raw     = bus.mem_q[ADDR_WIDTH-1:0];
  assign cnt_clamp   = (cnt_raw > MAX_N) ? MAX_N : cnt_raw;
  assign cnt_capture = (state == RD_WAIT) && wait_q;
  assign beat_clamp  = (beat_cnt > MAX_N) ? MAX_N : beat_cnt;
  assign wr_rdy      = (state == WR) && !wr_fin_q;
  assign wr_accept   = bus.wr_valid && wr_rdy;

  always_comb begin
    state_nxt = state;
    addr_nxt  = '0;
    data_nxt  = '0;
    rden_nxt  = 1'b0;
    wren_nxt  = 1'b0;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd_req && (!bus.wr_valid || last_grant == GRANT_WR)) begin
          grant_rd  = 1'b1;
          rden_nxt  = 1'b1;
          state_nxt = RD_CNT;
        end else if (bus.wr_valid) begin
          grant_wr  = 1'b1;
          state_nxt = WR;
        end
      end
      RD_CNT: state_nxt = RD_WAIT;
      // Second wait cycle is when the count word arrives from the RAM.
      RD_WAIT: begin
        if (wait_q) begin
          if (cnt_clamp == '0) begin
            state_nxt = IDLE;
          end else begin
            addr_nxt  = ADDR_WIDTH'(1);
            rden_nxt  = 1'b1;
            state_nxt = RD_STREAM;
          end
        end
      end
      RD_STREAM: begin
        if (addr_q == n_q) begin
          state_nxt = RD_DRAIN;
        end else begin
          addr_nxt = addr_q + ADDR_WIDTH'(1);
          rden_nxt = 1'b1;
        end
      end
      RD_DRAIN: if (!v1_q) state_nxt = IDLE;
      WR: begin
        if (wr_fin_q) begin
          wren_nxt  = 1'b1;
          data_nxt  = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, beat_clamp};
          state_nxt = WR_CNT;
        end else if (wr_accept && beat_cnt < MAX_N) begin
          wren_nxt = 1'b1;
          addr_nxt = beat_cnt + ADDR_WIDTH'(1);
          data_nxt = bus.wr_data;
        end
      end
      WR_CNT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_WR;
      addr_q     <= '0;
      data_q     <= '0;
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      wait_q     <= 1'b0;
      n_q        <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      id1_q      <= '0;
      id2_q      <= '0;
      beat_cnt   <= '0;
      wr_fin_q   <= 1'b0;
      rd_zero_q  <= 1'b0;
      cnt_err_q  <= 1'b0;
      wr_ovf_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      rden_q <= rden_nxt;
      wren_q <= wren_nxt;
      if (grant_rd) last_grant <= GRANT_RD;
      if (grant_wr) last_grant <= GRANT_WR;
      wait_q    <= (state == RD_WAIT) && !wait_q;
      rd_zero_q <= cnt_capture && (cnt_clamp == '0);
      if (cnt_capture) n_q <= cnt_clamp;
      if (cnt_capture && cnt_raw > MAX_N) cnt_err_q <= 1'b1;
      // Every RD_STREAM cycle carries one issued data read; delay it to meet mem_q.
      v1_q  <= (state == RD_STREAM);
      id1_q <= addr_q;
      v2_q  <= v1_q;
      id2_q <= id1_q;
      if (grant_wr) begin
        beat_cnt <= '0;
        wr_fin_q <= 1'b0;
      end else if (wr_accept) begin
        if (beat_cnt != CNT_SAT) beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
        if (bus.wr_last) wr_fin_q <= 1'b1;
        if (beat_cnt >= MAX_N) wr_ovf_q <= 1'b1;
      end
    end
  end

  assign beat_last       = v2_q && (id2_q == n_q);
  assign bus.rd_ack      = (state == RD_CNT);
  assign bus.pos_valid   = v2_q;
  assign bus.pos_out     = v2_q ? bus.mem_q : '0;
  assign bus.particle_id = v2_q ? id2_q : '0;
  assign bus.pos_last    = beat_last;
  assign bus.rd_done     = rd_zero_q || beat_last;
  assign bus.wr_ready    = wr_rdy;
  assign bus.wr_done     = (state == WR_CNT);
  assign bus.wr_ovf      = wr_ovf_q;
  assign bus.cnt_err     = cnt_err_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_rden    = rden_q;
  assign bus.mem_wren    = wren_q;
endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Bench for pos_cell_access_ctrl: RAM model with 2-cycle read latency plus a read-beat scoreboard.
module tb_pos_cell_access_ctrl;
  typedef struct packed {
    logic        last;
    logic [7:0]  id;
    logic [95:0] dat;
  } beat_t;

  logic clk;
  logic rst_n;
  pos_cell_access_ctrl_if #(.DATA_WIDTH(96), .ADDR_WIDTH(8)) bus();

  pos_cell_access_ctrl #(.DATA_WIDTH(96), .PARTICLE_NUM(220), .ADDR_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          beats    = 0;
  int          last_beat_cyc = 0;
  int          exp_n    = 0;
  logic        exp_ovf;
  beat_t       exp_q[$];
  logic [95:0] ref_mem [0:219];

  logic [95:0] ram [0:219];
  logic [95:0] q1;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [95:0] pre_dat;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] mk(input int seed, input int k);
    return {32'(seed), 32'(k), 32'hC0DE_0000 ^ 32'(k * 7)};
  endfunction

  function automatic int ref_cnt();
    int rc;
    rc = int'(ref_mem[0][7:0]);
    return (rc > 219) ? 219 : rc;
  endfunction

  // Single-port RAM: address/rden in cycle c, data on mem_q in cycle c+2.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_dat;
    else if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
    if (bus.mem_rden) q1 <= ram[bus.mem_address];
    bus.mem_q <= q1;
  end

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    chk("mem_excl", bus.mem_rden & bus.mem_wren, 0);
    if (!bus.mem_rden && !bus.mem_wren) chk("mem_idle", {bus.mem_address, bus.mem_data}, 0);
    if (bus.pos_valid) begin
      beats++;
      chk("pos_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pos_out", bus.pos_out, e.dat);
        chk("particle_id", bus.particle_id, e.id);
        chk("pos_last", bus.pos_last, e.last);
        chk("rd_done_beat", bus.rd_done, e.last);
        if (e.id > 1) chk("pos_gap", cyc - last_beat_cyc, 1);
      end
      last_beat_cyc = cyc;
    end
  end

  task automatic preload(input logic [7:0] a, input logic [95:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic start_read();
    exp_n = ref_cnt();
    for (int i = 1; i <= exp_n; i++) exp_q.push_back({(i == exp_n), 8'(i), ref_mem[i]});
    bus.rd_req = 1'b1;
  endtask

  task automatic finish_read();
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.rd_ack && c < 50);
    chk("rd_ack_seen", bus.rd_ack, 1);
    chk("rd_ack_addr", bus.mem_address, 0);
    chk("rd_ack_rden", bus.mem_rden, 1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.rd_done && c < 300);
    chk("rd_done_lat", c, (exp_n == 0) ? 3 : exp_n + 4);
    #1;
    chk("rd_q_empty", exp_q.size(), 0);
  endtask

  task automatic do_write(input int n, input int seed);
    int   k, stall, c;
    logic acc;
    k = 1;
    stall = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = mk(seed, 1);
    bus.wr_last  = (n == 1);
    while (k <= n && stall <= 1000) begin
      @(negedge clk);
      acc = bus.wr_ready;
      chk("wr_no_rdack", bus.rd_ack, 0);
      @(posedge clk); #1;
      if (acc) begin
        if (k <= 219) ref_mem[k] = mk(seed, k);
        k++;
        bus.wr_data = mk(seed, k);
        bus.wr_last = (k == n);
      end else begin
        stall++;
      end
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    chk("wr_stall", stall > 1000, 0);
    if (n > 219) exp_ovf = 1'b1;
    ref_mem[0] = 96'((n > 219) ? 219 : n);
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.wr_done && c < 10);
    chk("wr_done_lat", c, 2);
    chk("wr_ovf", bus.wr_ovf, exp_ovf);
  endtask

  task automatic check_ram();
    for (int i = 0; i <= ref_cnt(); i++) chk("ram_word", ram[i], ref_mem[i]);
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, {bus.rd_ack, bus.pos_valid, bus.pos_last, bus.rd_done, bus.wr_ready, bus.wr_done,
              bus.wr_ovf, bus.cnt_err, bus.mem_rden, bus.mem_wren}, 0);
    chk(tag, {bus.pos_out, bus.particle_id, bus.mem_address, bus.mem_data}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d limit=40000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_last = 1'b0;
    bus.wr_data = '0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_dat = '0;
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_outs");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three-beat write then full read back.
    do_write(3, 1);
    @(posedge clk); #1;
    check_ram();
    start_read();
    finish_read();
    chk("cnt_err_clear", bus.cnt_err, 0);

    // Empty cell.
    preload(8'd0, 96'd0);
    start_read();
    finish_read();

    // Tie in the first cycle after reset: read first, then the next tie goes to write.
    rst_n = 1'b0;
    exp_ovf = 1'b0;
    preload(8'd0, 96'd2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_read();
    bus.wr_valid = 1'b1;
    bus.wr_data  = mk(2, 1);
    bus.wr_last  = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; chk("t2_wr_blocked", bus.wr_ready, 0); end
    while (!bus.rd_ack && c < 20);
    chk("t2_rd_first", bus.rd_ack, 1);
    c = 0;
    do begin @(negedge clk); c++; chk("t2_wr_blocked", bus.wr_ready, 0); end
    while (!bus.rd_done && c < 50);
    chk("t2_rd_done_lat", c, 6);
    #1;
    chk("t2_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("t2_tie_wr", bus.wr_ready, 1);
    chk("t2_tie_no_rdack", bus.rd_ack, 0);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    ref_mem[1] = mk(2, 1);
    ref_mem[0] = 96'd1;
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.wr_done && c < 10);
    chk("t2_wr_done_lat", c, 2);

    // Overflowing write, then a clamped count word.
    do_write(221, 4);
    @(posedge clk); #1;
    check_ram();
    chk("t4_ram0", ram[0], 96'd219);
    preload(8'd0, 96'd250);
    start_read();
    finish_read();
    chk("t4_cnt_err", bus.cnt_err, 1);

    // Reset after five beats, then the held request restarts the burst.
    beats = 0;
    start_read();
    c = 0;
    while (beats < 5 && c < 100) begin @(negedge clk); #1; c++; end
    chk("t5_beats", beats, 5);
    rst_n = 1'b0;
    #1;
    check_quiet("t5_rst_outs");
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_read();
    finish_read();
    chk("t5_cnt_err", bus.cnt_err, 1);

    // Back-to-back write/read bursts; rd_req held through the first write.
    bus.rd_req = 1'b1;
    do_write(6, 6);
    start_read();
    finish_read();
    do_write(4, 7);
    start_read();
    finish_read();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
